// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the fetch stage and its branch target buffer.
//   NOP_INSTR     : instruction substituted on the wrong-path slot (addi x0,x0,0)
//   CTR_WT/CTR_ST : weakly / strongly taken 2-bit counter values
//   btb_entry_t   : one BTB entry (tag and target are word addresses, pc[31:2])
//   ctr_update    : 2-bit saturating counter step
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [1:0]  CTR_WT    = 2'b10;
  localparam logic [1:0]  CTR_ST    = 2'b11;

  // Tag is held right-aligned in a 30-bit field so the struct does not depend
  // on the table size; the unused upper bits are always zero.
  typedef struct packed {
    logic        valid;
    logic [29:0] tag;
    logic [29:0] target;
    logic [1:0]  ctr;
  } btb_entry_t;

  // Saturating increment on taken, saturating decrement on not-taken.
  function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    if (taken) begin
      res = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      res = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return res;
  endfunction

endpackage

// File: rtl/branch_target_buffer.sv
// -----------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB with 2-bit saturating counters.
//   clk, rst_n       : clock, async active-low reset (clears valid bits only)
//   lookup_pc_i      : PC looked up combinationally
//   pred_taken_o     : hit and counter MSB set
//   pred_target_o    : stored target of the indexed entry (word aligned)
//   upd_valid_i      : resolve/update strobe from execute
//   upd_pc_i         : PC of the resolved instruction (selects the entry)
//   upd_is_jump_i    : resolved instruction is an unconditional jump
//   upd_taken_i      : actual outcome
//   upd_target_i     : actual taken target
// -----------------------------------------------------------------------------
module branch_target_buffer
  import fetch_pkg::*;
#(
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] lookup_pc_i,
  output logic        pred_taken_o,
  output logic [31:0] pred_target_o,
  input  logic        upd_valid_i,
  input  logic [31:0] upd_pc_i,
  input  logic        upd_is_jump_i,
  input  logic        upd_taken_i,
  input  logic [31:0] upd_target_i
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [29:0]            tag_q    [BTB_ENTRIES];
  logic [29:0]            target_q [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];

  logic [IDX-1:0] rd_idx_s;
  logic [IDX-1:0] wr_idx_s;
  btb_entry_t     rd_entry_s;
  btb_entry_t     upd_entry_s;
  btb_entry_t     nxt_entry_s;
  logic           upd_hit_s;
  logic           wr_en_s;
  logic           unused_s;

  // Tag is the word address with the index bits shifted out.
  function automatic logic [29:0] tag_of(input logic [31:0] pc);
    return pc[31:2] >> IDX;
  endfunction

  assign rd_idx_s = lookup_pc_i[IDX+1:2];
  assign wr_idx_s = upd_pc_i[IDX+1:2];
  assign unused_s = ^{lookup_pc_i[1:0], upd_pc_i[1:0], upd_target_i[1:0]};

  // Lookup port: read the indexed entry and form the prediction.
  always_comb begin
    rd_entry_s.valid  = valid_q[rd_idx_s];
    rd_entry_s.tag    = tag_q[rd_idx_s];
    rd_entry_s.target = target_q[rd_idx_s];
    rd_entry_s.ctr    = ctr_q[rd_idx_s];
    pred_taken_o  = rd_entry_s.valid && (rd_entry_s.tag == tag_of(lookup_pc_i)) && rd_entry_s.ctr[1];
    pred_target_o = {rd_entry_s.target, 2'b00};
  end

  // Update port: compute the replacement entry for the resolved PC.
  always_comb begin
    upd_entry_s.valid  = valid_q[wr_idx_s];
    upd_entry_s.tag    = tag_q[wr_idx_s];
    upd_entry_s.target = target_q[wr_idx_s];
    upd_entry_s.ctr    = ctr_q[wr_idx_s];
    upd_hit_s   = upd_entry_s.valid && (upd_entry_s.tag == tag_of(upd_pc_i));
    nxt_entry_s = upd_entry_s;
    wr_en_s     = 1'b0;
    if (upd_valid_i) begin
      if (upd_hit_s) begin
        wr_en_s = 1'b1;
        if (upd_is_jump_i) begin
          nxt_entry_s.ctr    = CTR_ST;
          nxt_entry_s.target = upd_target_i[31:2];
        end else begin
          nxt_entry_s.ctr = ctr_update(upd_entry_s.ctr, upd_taken_i);
          if (upd_taken_i) begin
            nxt_entry_s.target = upd_target_i[31:2];
          end else begin
            nxt_entry_s.target = upd_entry_s.target;
          end
        end
      end else if (upd_taken_i) begin
        // Miss on a taken transfer: replace whatever occupies the slot.
        wr_en_s            = 1'b1;
        nxt_entry_s.valid  = 1'b1;
        nxt_entry_s.tag    = tag_of(upd_pc_i);
        nxt_entry_s.target = upd_target_i[31:2];
        nxt_entry_s.ctr    = upd_is_jump_i ? CTR_ST : CTR_WT;
      end else begin
        wr_en_s = 1'b0;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Valid bits: the only BTB state cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (wr_en_s) begin
      valid_q[wr_idx_s] <= nxt_entry_s.valid;
    end else begin
      valid_q <= valid_q;
    end
  end

  // Tag/target/counter storage, written without reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      tag_q[wr_idx_s]    <= nxt_entry_s.tag;
      target_q[wr_idx_s] <= nxt_entry_s.target;
      ctr_q[wr_idx_s]    <= nxt_entry_s.ctr;
    end
  end

endmodule

// File: rtl/fetch_predict.sv
// -----------------------------------------------------------------------------
// fetch_predict
// Instruction fetch stage: PC register, next-PC selection, BTB prediction and
// wrong-path NOP insertion.
//   clk, rst_n        : clock, async active-low reset
//   stall             : hold the PC
//   imem_addr/rdata   : combinational instruction memory port (addr = pc_f)
//   instr_f, pc_f, pc_plus4_f, pred_taken_f, pred_pc_f : fetch operands
//   ex_valid, ex_pc, ex_is_jump, ex_taken, ex_target   : BTB training
//   redirect, redirect_pc : restart fetch at the corrected PC
// -----------------------------------------------------------------------------
module fetch_predict
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_f,
  output logic [31:0] pc_plus4_f,
  output logic        pred_taken_f,
  output logic [31:0] pred_pc_f,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_is_jump,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic        btb_taken_s;
  logic [31:0] btb_target_s;
  logic        unused_s;

  branch_target_buffer #(
    .BTB_ENTRIES(BTB_ENTRIES)
  ) u_btb (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_pc_i   (pc_q),
    .pred_taken_o  (btb_taken_s),
    .pred_target_o (btb_target_s),
    .upd_valid_i   (ex_valid),
    .upd_pc_i      (ex_pc),
    .upd_is_jump_i (ex_is_jump),
    .upd_taken_i   (ex_taken),
    .upd_target_i  (ex_target)
  );

  assign unused_s   = ^redirect_pc[1:0];
  assign pc_f       = pc_q;
  assign imem_addr  = pc_q;
  assign pc_plus4_f = pc_q + 32'd4;
  // The predicted PC is the raw BTB result; a redirect only squashes the
  // visible taken flag and instruction, the next-PC mux ignores it anyway.
  assign pred_pc_f    = btb_taken_s ? btb_target_s : pc_plus4_f;
  assign pred_taken_f = btb_taken_s & ~redirect;
  assign instr_f      = redirect ? NOP_INSTR : imem_rdata;

  // Next-PC priority: redirect, then stall, then prediction.
  always_comb begin
    pc_d = pred_pc_f;
    if (redirect) begin
      pc_d = {redirect_pc[31:2], 2'b00};
    end else if (stall) begin
      pc_d = pc_q;
    end else begin
      pc_d = pred_pc_f;
    end
  end

  // Program counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

endmodule
